// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: prioritises interrupts, exceptions and mret, then
// walks a fixed IDLE -> COMMIT -> REDIRECT sequence. Also owns mtime/mtimecmp.
module trap_ctrl #(
    parameter int unsigned TICK_DIV         = 1,
    parameter logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] pc,
    input  logic        illegal_inst,
    input  logic        ecall,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic        sw_irq,
    input  logic        mstatus_mie,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        tcmp_we,
    input  logic        tcmp_hi,
    input  logic [31:0] tcmp_wdata,
    output logic        stall,
    output logic        trap_take,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_epc,
    output logic        mret_take,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mip,
    output logic [63:0] mtime,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] mtimecmp;
    logic [15:0] presc;
    logic        tick;
    logic        mtip;
    logic        mei, msi, mti;
    logic        ev_hit, ev_mret, take;
    logic [31:0] ev_cause;
    logic [31:0] lat_cause, lat_epc, lat_target;
    logic        lat_mret;
    logic        unused_mie_bits;

    assign unused_mie_bits = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};
    assign fsm_state       = state;

    // Timer: prescaler wraps every TICK_DIV cycles and advances mtime; runs during stall.
    assign tick = (presc == 16'(TICK_DIV - 1));
    assign mtip = (mtime >= mtimecmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= 16'd0;
            mtime    <= 64'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick)
                mtime <= mtime + 64'd1;
            if (tcmp_we) begin
                if (tcmp_hi)
                    mtimecmp[63:32] <= tcmp_wdata;
                else
                    mtimecmp[31:0]  <= tcmp_wdata;
            end
        end
    end

    assign mip = {20'd0, ext_irq, 3'd0, mtip, 3'd0, sw_irq, 3'd0};

    assign mei = ext_irq & mie[11] & mstatus_mie;
    assign msi = sw_irq  & mie[3]  & mstatus_mie;
    assign mti = mtip    & mie[7]  & mstatus_mie;

    // Priority encoder; a winning interrupt discards the instruction's own flags.
    always_comb begin
        ev_hit   = 1'b1;
        ev_mret  = 1'b0;
        ev_cause = 32'd0;
        if (mei)               ev_cause = 32'h8000_000B;
        else if (msi)          ev_cause = 32'h8000_0003;
        else if (mti)          ev_cause = 32'h8000_0007;
        else if (illegal_inst) ev_cause = 32'h0000_0002;
        else if (ecall)        ev_cause = 32'h0000_000B;
        else if (mret)         ev_mret  = 1'b1;
        else                   ev_hit   = 1'b0;
    end

    assign take = (state == ST_IDLE) && inst_valid && ev_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_cause  <= 32'd0;
            lat_epc    <= 32'd0;
            lat_target <= 32'd0;
            lat_mret   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                lat_cause  <= ev_cause;
                lat_epc    <= pc;
                lat_mret   <= ev_mret;
                lat_target <= ev_mret ? mepc : (mtvec & MTVEC_ALIGN_MASK);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (take) state_nxt = ST_COMMIT;
            ST_COMMIT:   state_nxt = ST_REDIRECT;
            ST_REDIRECT: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Pulses are single-cycle and unconditional (no ready); rst masks any in flight.
    always_comb begin
        stall          = !rst && (take || state != ST_IDLE);
        trap_take      = !rst && state == ST_COMMIT && !lat_mret;
        mret_take      = !rst && state == ST_COMMIT && lat_mret;
        redirect_valid = !rst && state == ST_REDIRECT;
        trap_cause     = trap_take ? lat_cause : 32'd0;
        trap_epc       = trap_take ? lat_epc : 32'd0;
        redirect_pc    = redirect_valid ? lat_target : 32'd0;
    end

endmodule
